spi_burst_ctrl: RTL and testbench
=================================

Name: spi_burst_ctrl

Overview:
Register-side sequencer that sits directly upstream of the SPI byte engine. It owns the engine's txdata/txstart/rxdata/busy handshake. It buffers outgoing bytes in a TX FIFO and incoming bytes in an RX FIFO, so the CPU bus can queue several bytes without polling busy per byte. It also generates read bursts of dummy bytes and drives the chip-select line.

Parameters:
FIFO_DEPTH, 4, entries per FIFO; power of 2, minimum 2.
DUMMY_BYTE, 8'hFF, byte transmitted for each burst-read transfer.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
wr_data  in  8  byte to queue for transmit.
wr_en  in  1  push wr_data into the TX FIFO.
rx_keep  in  1  sampled with wr_en; 1 = keep the byte received for this entry, 0 = discard it.
tx_full  out  1  TX FIFO full.
rd_en  in  1  pop the RX FIFO head.
rd_data  out  8  RX FIFO head (show-ahead).
rx_empty  out  1  RX FIFO empty.
rx_count  out  log2(FIFO_DEPTH)+1  RX FIFO occupancy.
burst_len  in  8  number of dummy bytes for a read burst.
burst_start  in  1  load burst_len into the burst counter.
cs_wr  in  1  write the chip-select register.
cs_val  in  1  chip-select register value; 1 = select.
spi_cs_n  out  1  active-low chip select = !cs register.
xfer_active  out  1  high when FSM != IDLE, TX FIFO non-empty, or burst counter != 0.
eng_txdata  out  8  byte to the engine, registered.
eng_txstart  out  1  one-cycle start pulse to the engine, registered.
eng_rxdata  in  8  last received byte from the engine.
eng_busy  in  1  engine busy.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, both FIFOs empty, memories cleared.
  - Outputs: rd_data=0, rx_count=0, rx_empty=1, tx_full=0.
  - Burst counter=0, cs register=0, so spi_cs_n=1.
  - eng_txstart=0, eng_txdata=0, xfer_active=0.
  - Reset mid-transfer aborts everything; the engine is not notified.
- TX FIFO: 9-bit entries {keep, data}.
  - wr_en while tx_full: write dropped, no state change.
  - DUMMY transfers are always kept (keep=1).
- RX FIFO: rd_en while rx_empty is ignored and rd_data holds.
  - Capture and rd_en in the same cycle both take effect; count is unchanged.
- FSM states:
  - IDLE: byte source selection, in priority order:
    - TX FIFO non-empty: pop the head.
    - Otherwise burst counter != 0: use DUMMY_BYTE and decrement the counter.
    - A source is taken only if the RX FIFO is not full.
    - When a source is taken, load eng_txdata and go to START.
  - START: eng_txstart=1 for exactly this cycle. Go to ACK.
  - ACK: wait until eng_busy=1, then go to DONE.
  - DONE: wait until eng_busy=0. At that edge, if keep=1, push eng_rxdata into the RX FIFO. Go to IDLE.
- Latency:
  - wr_en sampled at edge E0 produces eng_txstart high in the cycle after E1.
  - Engine busy falling, sampled at edge Ed, makes rx_empty deassert after Ed.
  - Minimum per-byte overhead beyond engine busy time: 3 cycles.
- Only one byte is ever outstanding, so RX capture never overflows. Gating on RX not-full stalls transfers instead of losing data.
- burst_start while the burst counter != 0: ignored. burst_start with burst_len=0: no effect.
- cs_wr is accepted only when xfer_active=0; otherwise it is ignored. cs_wr together with wr_en in the same cycle: cs_wr is applied (xfer_active was 0).
- The keep bit travels with its byte. Changing rx_keep later does not affect queued entries.

Test Plan:
- Reset then idle: spi_cs_n=1, rx_empty=1, tx_full=0, eng_txstart never pulses.
- Single byte: cs_wr=1/cs_val=1, then push 8'hA5 keep=1 with a behavioural engine (busy 16 cycles, returns 8'h3C).
  - One eng_txstart pulse 2 cycles after wr_en, eng_txdata=8'hA5.
  - rd_data=8'h3C, rx_count=1, spi_cs_n=0.
- Queue 4 bytes 01..04, keep=0,1,0,1:
  - tx_full after the 4th push; a 5th push is dropped.
  - Four starts in order; RX holds exactly the two kept replies.
- Burst: burst_len=6 with the engine returning 10..15, never popping RX:
  - 4 bytes captured, FSM stalls in IDLE, burst counter=2.
  - Popping two entries releases the last two; bytes arrive in order.
- TX priority: TX push during an active burst is sent before the next dummy. A cs_wr during the burst is ignored (spi_cs_n unchanged).
- rst_n low during DONE: all outputs at reset values within the same cycle. After release, no spurious capture or start.

Source files
------------

// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: feeds queued TX bytes and dummy read-burst bytes to an SPI byte
// engine one at a time, buffers the kept replies in an RX FIFO and owns chip select.
module spi_burst_ctrl #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] DUMMY_BYTE = 8'hFF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   wr_data,
    input  logic                         wr_en,
    input  logic                         rx_keep,
    output logic                         tx_full,
    input  logic                         rd_en,
    output logic [7:0]                   rd_data,
    output logic                         rx_empty,
    output logic [$clog2(FIFO_DEPTH):0]  rx_count,
    input  logic [7:0]                   burst_len,
    input  logic                         burst_start,
    input  logic                         cs_wr,
    input  logic                         cs_val,
    output logic                         spi_cs_n,
    output logic                         xfer_active,
    output logic [7:0]                   eng_txdata,
    output logic                         eng_txstart,
    input  logic [7:0]                   eng_rxdata,
    input  logic                         eng_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_ACK, S_DONE} state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [8:0]      r_txMem [FIFO_DEPTH];
    logic [AW-1:0]   r_txWp;
    logic [AW-1:0]   r_txRp;
    logic [CW-1:0]   r_txCount;
    logic [7:0]      r_rxMem [FIFO_DEPTH];
    logic [AW-1:0]   r_rxWp;
    logic [AW-1:0]   r_rxRp;
    logic [CW-1:0]   r_rxCount;
    logic [7:0]      r_burstCnt;
    logic            r_cs;
    logic            r_keep;
    logic            r_txstart;
    logic [7:0]      r_txdata;

    logic w_txEmpty;
    logic w_rxFull;
    logic w_txPush;
    logic w_txPop;
    logic w_dummyTake;
    logic w_rxPush;
    logic w_rxPop;

    assign w_txEmpty   = (r_txCount == '0);
    assign w_rxFull    = (r_rxCount == FULL_CNT);
    assign tx_full     = (r_txCount == FULL_CNT);
    assign rx_empty    = (r_rxCount == '0);
    assign rx_count    = r_rxCount;
    assign rd_data     = r_rxMem[r_rxRp];
    assign w_txPush    = wr_en && !tx_full;
    assign w_rxPop     = rd_en && !rx_empty;
    assign spi_cs_n    = !r_cs;
    assign xfer_active = (r_state != S_IDLE) || !w_txEmpty || (r_burstCnt != 8'd0);
    assign eng_txdata  = r_txdata;
    assign eng_txstart = r_txstart;

    // A new byte is only launched while the RX FIFO has room for its reply.
    always_comb begin
        w_stateNext = r_state;
        w_txPop     = 1'b0;
        w_dummyTake = 1'b0;
        w_rxPush    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rxFull) begin
                    if (!w_txEmpty) begin
                        w_txPop     = 1'b1;
                        w_stateNext = S_START;
                    end else if (r_burstCnt != 8'd0) begin
                        w_dummyTake = 1'b1;
                        w_stateNext = S_START;
                    end
                end
            end
            S_START: w_stateNext = S_ACK;
            S_ACK: begin
                if (eng_busy) w_stateNext = S_DONE;
            end
            S_DONE: begin
                if (!eng_busy) begin
                    w_rxPush    = r_keep;
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_txstart <= 1'b0;
            r_txdata  <= 8'h00;
            r_keep    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_txstart <= (w_stateNext == S_START);
            if (w_txPop) begin
                r_txdata <= r_txMem[r_txRp][7:0];
                r_keep   <= r_txMem[r_txRp][8];
            end else if (w_dummyTake) begin
                r_txdata <= DUMMY_BYTE;
                r_keep   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_txMem[i] <= '0;
            r_txWp    <= '0;
            r_txRp    <= '0;
            r_txCount <= '0;
        end else begin
            if (w_txPush) begin
                r_txMem[r_txWp] <= {rx_keep, wr_data};
                r_txWp          <= r_txWp + 1'b1;
            end
            if (w_txPop) r_txRp <= r_txRp + 1'b1;
            case ({w_txPush, w_txPop})
                2'b10:   r_txCount <= r_txCount + 1'b1;
                2'b01:   r_txCount <= r_txCount - 1'b1;
                default: r_txCount <= r_txCount;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_rxMem[i] <= '0;
            r_rxWp    <= '0;
            r_rxRp    <= '0;
            r_rxCount <= '0;
        end else begin
            if (w_rxPush) begin
                r_rxMem[r_rxWp] <= eng_rxdata;
                r_rxWp          <= r_rxWp + 1'b1;
            end
            if (w_rxPop) r_rxRp <= r_rxRp + 1'b1;
            case ({w_rxPush, w_rxPop})
                2'b10:   r_rxCount <= r_rxCount + 1'b1;
                2'b01:   r_rxCount <= r_rxCount - 1'b1;
                default: r_rxCount <= r_rxCount;
            endcase
        end
    end

    // Burst reload only when the counter has drained; chip select only while quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burstCnt <= 8'd0;
            r_cs       <= 1'b0;
        end else begin
            if (w_dummyTake) begin
                r_burstCnt <= r_burstCnt - 1'b1;
            end else if (burst_start && (r_burstCnt == 8'd0)) begin
                r_burstCnt <= burst_len;
            end
            if (cs_wr && !xfer_active) r_cs <= cs_val;
        end
    end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// tb_spi_burst_ctrl: drives spi_burst_ctrl against a behavioural SPI byte engine;
// expected engine bytes and RX replies are queued when stimulus is applied.
`timescale 1ns/1ps
module tb_spi_burst_ctrl;

    localparam int FIFO_DEPTH = 4;
    localparam int ENG_BUSY   = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       rx_keep;
    logic       tx_full;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rx_empty;
    logic [2:0] rx_count;
    logic [7:0] burst_len;
    logic       burst_start;
    logic       cs_wr;
    logic       cs_val;
    logic       spi_cs_n;
    logic       xfer_active;
    logic [7:0] eng_txdata;
    logic       eng_txstart;

    logic       engBusy = 1'b0;
    logic [7:0] engRx = 8'h00;
    logic [7:0] engCur = 8'h00;
    int         engCnt = 0;

    logic [7:0] engReplies[$];
    logic [7:0] expTx[$];
    logic [7:0] expRx[$];

    int compared = 0;
    int mismatched = 0;
    int startCount = 0;
    int base = 0;

    typedef struct {
        logic [7:0] data;
        logic       keep;
        logic [7:0] reply;
        logic       accepted;
        logic       expFull;
    } txVec_t;

    txVec_t vecs[5];

    spi_burst_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .DUMMY_BYTE(8'hFF)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .rx_keep(rx_keep),
        .tx_full(tx_full),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rx_empty(rx_empty),
        .rx_count(rx_count),
        .burst_len(burst_len),
        .burst_start(burst_start),
        .cs_wr(cs_wr),
        .cs_val(cs_val),
        .spi_cs_n(spi_cs_n),
        .xfer_active(xfer_active),
        .eng_txdata(eng_txdata),
        .eng_txstart(eng_txstart),
        .eng_rxdata(engRx),
        .eng_busy(engBusy)
    );

    always #5 clk = ~clk;

    // Engine: busy for ENG_BUSY cycles after a start, then presents its queued reply.
    always @(posedge clk) begin
        if (eng_txstart && !engBusy) begin
            engBusy <= 1'b1;
            engCnt  <= ENG_BUSY;
            if (engReplies.size() > 0) engCur <= engReplies.pop_front();
            else                       engCur <= 8'h00;
        end else if (engBusy) begin
            engCnt <= engCnt - 1;
            if (engCnt == 1) begin
                engBusy <= 1'b0;
                engRx   <= engCur;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Every start pulse must match the next byte the scoreboard predicted.
    initial begin
        forever begin
            @(negedge clk);
            if (eng_txstart) begin
                startCount++;
                if (expTx.size() == 0) checkOutput("spurious_start", 1, 0);
                else checkOutput("eng_txdata", eng_txdata, expTx.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] data, input logic keep,
                                 input logic [7:0] reply, input logic accepted);
        @(negedge clk);
        wr_data = data;
        rx_keep = keep;
        wr_en   = 1'b1;
        if (accepted) begin
            expTx.push_back(data);
            engReplies.push_back(reply);
            if (keep) expRx.push_back(reply);
        end
        @(negedge clk);
        wr_en   = 1'b0;
        rx_keep = 1'b0;
    endtask

    task automatic popRx(input string name);
        @(negedge clk);
        if (expRx.size() == 0) checkOutput({name, "_unexpected"}, 1, 0);
        else checkOutput(name, rd_data, expRx.pop_front());
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles, input string name);
        int n = 0;
        while ((xfer_active || engBusy) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, (xfer_active || engBusy), 0);
    endtask

    task automatic waitEngBusy(input int maxCycles, input string name);
        int n = 0;
        while (!engBusy && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, engBusy, 1);
    endtask

    task automatic waitBusyFall(input int maxCycles, input string name);
        int n = 0;
        while (!engBusy && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        while (engBusy && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, (n >= maxCycles), 0);
    endtask

    task automatic waitRxCount(input int target, input int maxCycles, input string name);
        int n = 0;
        while (int'(rx_count) != target && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, rx_count, target);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        wr_data = 8'h00; wr_en = 1'b0; rx_keep = 1'b0; rd_en = 1'b0;
        burst_len = 8'h00; burst_start = 1'b0; cs_wr = 1'b0; cs_val = 1'b0;

        vecs[0] = '{data: 8'h01, keep: 1'b0, reply: 8'h81, accepted: 1'b1, expFull: 1'b0};
        vecs[1] = '{data: 8'h02, keep: 1'b1, reply: 8'h82, accepted: 1'b1, expFull: 1'b0};
        vecs[2] = '{data: 8'h03, keep: 1'b0, reply: 8'h83, accepted: 1'b1, expFull: 1'b0};
        vecs[3] = '{data: 8'h04, keep: 1'b1, reply: 8'h84, accepted: 1'b1, expFull: 1'b1};
        vecs[4] = '{data: 8'h05, keep: 1'b1, reply: 8'h85, accepted: 1'b0, expFull: 1'b1};

        // Reset values, then a quiet idle period.
        repeat (2) @(negedge clk);
        checkOutput("rst_spi_cs_n", spi_cs_n, 1);
        checkOutput("rst_rx_empty", rx_empty, 1);
        checkOutput("rst_tx_full", tx_full, 0);
        checkOutput("rst_rx_count", rx_count, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        checkOutput("rst_txstart", eng_txstart, 0);
        checkOutput("rst_txdata", eng_txdata, 0);
        checkOutput("rst_xfer_active", xfer_active, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        rd_en = 1'b1; burst_len = 8'd0; burst_start = 1'b1;
        @(negedge clk);
        rd_en = 1'b0; burst_start = 1'b0;
        checkOutput("idle_rd_data", rd_data, 0);
        checkOutput("idle_rx_count", rx_count, 0);
        checkOutput("idle_zero_burst", xfer_active, 0);
        repeat (5) @(negedge clk);
        checkOutput("idle_starts", startCount, 0);

        // Single byte with chip select asserted first.
        @(negedge clk); cs_wr = 1'b1; cs_val = 1'b1;
        @(negedge clk); cs_wr = 1'b0; cs_val = 1'b0;
        checkOutput("cs_select", spi_cs_n, 0);
        applyStimulus(8'hA5, 1'b1, 8'h3C, 1'b1);
        checkOutput("start_early", eng_txstart, 0);
        @(negedge clk);
        checkOutput("start_pulse", eng_txstart, 1);
        checkOutput("start_data", eng_txdata, 8'hA5);
        @(negedge clk);
        checkOutput("start_single", eng_txstart, 0);
        waitBusyFall(60, "busy_fall");
        checkOutput("rx_before_capture", rx_empty, 1);
        @(negedge clk);
        checkOutput("rx_after_capture", rx_empty, 0);
        checkOutput("single_rd_data", rd_data, 8'h3C);
        checkOutput("single_rx_count", rx_count, 1);
        checkOutput("single_cs_n", spi_cs_n, 0);
        popRx("single_pop");
        waitIdle(50, "single_idle");

        // Preload keeps the engine busy so the table entries fill the TX FIFO.
        applyStimulus(8'h00, 1'b0, 8'hEE, 1'b1);
        waitEngBusy(20, "q_busy");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].data, vecs[i].keep, vecs[i].reply, vecs[i].accepted);
            checkOutput($sformatf("q_full%0d", i), tx_full, vecs[i].expFull);
        end
        waitIdle(400, "q_idle");
        checkOutput("q_rx_count", rx_count, 2);
        popRx("q_pop0");
        popRx("q_pop1");
        checkOutput("q_tx_drained", expTx.size(), 0);

        // Six-byte burst stalls on a full RX FIFO until the bench pops.
        base = startCount;
        for (int i = 0; i < 6; i++) begin
            expTx.push_back(8'hFF);
            engReplies.push_back(8'(8'h10 + i));
            expRx.push_back(8'(8'h10 + i));
        end
        @(negedge clk); burst_len = 8'd6; burst_start = 1'b1;
        @(negedge clk); burst_start = 1'b0; burst_len = 8'd0;
        waitRxCount(4, 400, "b_fill");
        repeat (40) @(negedge clk);
        checkOutput("b_stall_count", rx_count, 4);
        checkOutput("b_stall_active", xfer_active, 1);
        checkOutput("b_stall_starts", startCount - base, 4);
        @(negedge clk); burst_len = 8'd5; burst_start = 1'b1;
        @(negedge clk); burst_start = 1'b0; burst_len = 8'd0;
        popRx("b_pop0");
        popRx("b_pop1");
        waitIdle(300, "b_idle");
        checkOutput("b_final_count", rx_count, 4);
        checkOutput("b_total_starts", startCount - base, 6);
        for (int i = 0; i < 4; i++) popRx($sformatf("b_pop%0d", i + 2));
        checkOutput("b_rx_empty", rx_empty, 1);

        // TX push during a burst jumps ahead of the remaining dummies.
        base = startCount;
        expTx.push_back(8'hFF);
        engReplies.push_back(8'h21);
        expRx.push_back(8'h21);
        @(negedge clk); burst_len = 8'd3; burst_start = 1'b1;
        @(negedge clk); burst_start = 1'b0; burst_len = 8'd0;
        waitEngBusy(20, "p_busy");
        @(negedge clk);
        wr_data = 8'h5A; rx_keep = 1'b1; wr_en = 1'b1; cs_wr = 1'b1; cs_val = 1'b0;
        expTx.push_back(8'h5A); engReplies.push_back(8'h22); expRx.push_back(8'h22);
        expTx.push_back(8'hFF); engReplies.push_back(8'h23); expRx.push_back(8'h23);
        expTx.push_back(8'hFF); engReplies.push_back(8'h24); expRx.push_back(8'h24);
        @(negedge clk);
        wr_en = 1'b0; rx_keep = 1'b0; cs_wr = 1'b0;
        checkOutput("p_cs_held", spi_cs_n, 0);
        waitIdle(300, "p_idle");
        checkOutput("p_rx_count", rx_count, 4);
        checkOutput("p_starts", startCount - base, 4);
        for (int i = 0; i < 4; i++) popRx($sformatf("p_pop%0d", i));
        @(negedge clk); cs_wr = 1'b1; cs_val = 1'b0;
        @(negedge clk); cs_wr = 1'b0;
        checkOutput("p_cs_release", spi_cs_n, 1);

        // cs_wr with wr_en while quiet, then reset in the middle of the transfer.
        base = startCount;
        @(negedge clk);
        wr_data = 8'h77; rx_keep = 1'b1; wr_en = 1'b1; cs_wr = 1'b1; cs_val = 1'b1;
        expTx.push_back(8'h77);
        engReplies.push_back(8'h99);
        @(negedge clk);
        wr_en = 1'b0; rx_keep = 1'b0; cs_wr = 1'b0; cs_val = 1'b0;
        checkOutput("r_cs_with_wr", spi_cs_n, 0);
        waitEngBusy(20, "r_busy");
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("r_spi_cs_n", spi_cs_n, 1);
        checkOutput("r_rx_empty", rx_empty, 1);
        checkOutput("r_rx_count", rx_count, 0);
        checkOutput("r_rd_data", rd_data, 0);
        checkOutput("r_tx_full", tx_full, 0);
        checkOutput("r_txstart", eng_txstart, 0);
        checkOutput("r_txdata", eng_txdata, 0);
        checkOutput("r_xfer_active", xfer_active, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("r_post_rx_empty", rx_empty, 1);
        checkOutput("r_post_starts", startCount - base, 1);
        checkOutput("r_post_active", xfer_active, 0);
        checkOutput("r_tx_drained", expTx.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
